// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared constants for the flow-controlled FIFO: width defaults, threshold width
// and the all-empty vector the flow-control FSM compares its FIFO_empty bits against.
package fifo_flow_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int THR_W          = 3;
  localparam logic [9:0] ALL_EMPTY = 10'b1111111111;
endpackage

// File: rtl/fifo_flow_ctrl_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read.
// Storage is deliberately not reset; occupancy tracking lives in the top level.
module fifo_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with threshold flags for the flow-control FSM.
// Build option FIFO_COUNT_EN exposes occupancy and splits error into overflow/underflow.
module fifo_flow_ctrl
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [THR_W-1:0]      umbral_alto,
  input  logic [THR_W-1:0]      umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_COUNT_EN
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow_err,
  output logic                  underflow_err
`else
  output logic                  error
`endif
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  push_ok, pop_ok, ovf, udf;
  logic                  ovf_seen, udf_seen;
  logic [ADDR_WIDTH:0]   alto_ext, bajo_ext;

  assign fifo_empty = (fill_cnt == '0);
  assign fifo_full  = (fill_cnt == DEPTH_CNT);

  // A pop on a full FIFO frees the slot the same edge; no write-through when empty.
  assign push_ok = push && (!fifo_full || pop);
  assign pop_ok  = pop && !fifo_empty;
  assign ovf     = push && fifo_full && !pop;
  assign udf     = pop && fifo_empty;

  assign alto_ext     = {{(ADDR_WIDTH+1-THR_W){1'b0}}, umbral_alto};
  assign bajo_ext     = {{(ADDR_WIDTH+1-THR_W){1'b0}}, umbral_bajo};
  assign almost_full  = (umbral_alto != '0) && (fill_cnt >= alto_ext);
  assign almost_empty = (fill_cnt <= bajo_ext);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ovf_seen  <= 1'b0;
      udf_seen  <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_word;
      end
      if (push_ok && !pop_ok)      fill_cnt <= fill_cnt + 1'b1;
      else if (pop_ok && !push_ok) fill_cnt <= fill_cnt - 1'b1;
      if (ovf) ovf_seen <= 1'b1;
      if (udf) udf_seen <= 1'b1;
    end
  end

`ifdef FIFO_COUNT_EN
  assign count         = fill_cnt;
  assign overflow_err  = ovf_seen;
  assign underflow_err = udf_seen;
`else
  assign error = ovf_seen | udf_seen;
`endif
endmodule
